// File: rtl/alu_arbiter_if.sv
// Bundle between the two ALU requesters, the arbiter and the shared ALU instance.
// master = requester/ALU side, slave = alu_arbiter.
`ifndef DWORD_BITS
`define DWORD_BITS 32
`endif
`ifndef ALU_TYPE_BITS
`define ALU_TYPE_BITS 4
`endif

interface alu_arbiter_if #(
    parameter int DATA_SIZE = `DWORD_BITS,
    parameter int OP_BITS   = `ALU_TYPE_BITS
);
    logic                 flush;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [OP_BITS-1:0]   req_op0;
    logic [OP_BITS-1:0]   req_op1;
    logic [DATA_SIZE-1:0] req_a0;
    logic [DATA_SIZE-1:0] req_a1;
    logic [DATA_SIZE-1:0] req_b0;
    logic [DATA_SIZE-1:0] req_b1;
    logic [DATA_SIZE-1:0] alu_src1;
    logic [DATA_SIZE-1:0] alu_src2;
    logic [OP_BITS-1:0]   alu_op;
    logic [DATA_SIZE-1:0] alu_result;
    logic                 alu_zero;
    logic [1:0]           rsp_valid;
    logic [1:0]           rsp_ready;
    logic [DATA_SIZE-1:0] rsp_data;
    logic                 rsp_zero;

    modport master (
        output flush, req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
               rsp_ready, alu_result, alu_zero,
        input  req_ready, alu_src1, alu_src2, alu_op, rsp_valid, rsp_data, rsp_zero
    );

    modport slave (
        input  flush, req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
               rsp_ready, alu_result, alu_zero,
        output req_ready, alu_src1, alu_src2, alu_op, rsp_valid, rsp_data, rsp_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester valid/ready arbiter in front of one combinational ALU, single issue register.
// Define ALU_ARB_RR_EN for round-robin on contention; otherwise requester 0 always wins.
`ifndef DWORD_BITS
`define DWORD_BITS 32
`endif
`ifndef ALU_TYPE_BITS
`define ALU_TYPE_BITS 4
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'h0
`endif

module alu_arbiter #(
    parameter int DATA_SIZE = `DWORD_BITS,
    parameter int OP_BITS   = `ALU_TYPE_BITS
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;
    logic [OP_BITS-1:0]   op_q, op_d;
    logic [DATA_SIZE-1:0] a_q, a_d;
    logic [DATA_SIZE-1:0] b_q, b_d;

    logic                 prio;
    logic                 contend;
    logic                 grant;
    logic                 fire;
    logic                 accept;
    logic [1:0]           req_ready;
    logic [1:0]           rsp_valid;
    logic [DATA_SIZE-1:0] alu_src1;
    logic [DATA_SIZE-1:0] alu_src2;
    logic [OP_BITS-1:0]   alu_op;

    assign contend = &bus.req_valid;

`ifdef ALU_ARB_RR_EN
    logic prio_q;

    // Pointer only moves when both requesters competed, so a lone requester never steals a turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prio_q <= 1'b0;
        else if (accept && contend)
            prio_q <= ~grant;
    end

    assign prio = prio_q;
`else
    assign prio = 1'b0;
`endif

    assign grant  = contend ? prio : bus.req_valid[1];
    assign fire   = (state_q == BUSY) && bus.rsp_ready[owner_q];
    assign accept = (|bus.req_valid) && !bus.flush && ((state_q == IDLE) || fire);

    assign req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        // NOTE: every target gets a default first so no branch can infer a latch.
        state_d = state_q;
        owner_d = owner_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        if (bus.flush) begin
            state_d = IDLE;
            owner_d = 1'b0;
            op_d    = '0;
            a_d     = '0;
            b_d     = '0;
        end else if (accept) begin
            state_d = BUSY;
            owner_d = grant;
            op_d    = grant ? bus.req_op1 : bus.req_op0;
            a_d     = grant ? bus.req_a1  : bus.req_a0;
            b_d     = grant ? bus.req_b1  : bus.req_b0;
        end else if (fire) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking so every register samples the pre-edge values of its peers.
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // An empty issue register presents ADD 0+0 so the ALU output is a known zero.
    always_comb begin
        alu_src1  = '0;
        alu_src2  = '0;
        alu_op    = OP_BITS'(`ALU_ADD);
        rsp_valid = 2'b00;
        if (state_q == BUSY) begin
            alu_src1  = a_q;
            alu_src2  = b_q;
            alu_op    = op_q;
            rsp_valid = owner_q ? 2'b10 : 2'b01;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.alu_src1  = alu_src1;
    assign bus.alu_src2  = alu_src2;
    assign bus.alu_op    = alu_op;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = bus.alu_result;
    assign bus.rsp_zero  = bus.alu_zero;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed table, hand sequences, then random traffic
// against a transaction-level reference model. Follows ALU_ARB_RR_EN if defined.
`ifndef DWORD_BITS
`define DWORD_BITS 32
`endif
`ifndef ALU_TYPE_BITS
`define ALU_TYPE_BITS 4
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'h0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'h1
`endif
`ifndef ALU_AND
`define ALU_AND 4'h2
`endif
`ifndef ALU_OR
`define ALU_OR 4'h3
`endif
`ifndef ALU_XOR
`define ALU_XOR 4'h4
`endif
`ifndef ALU_SLT
`define ALU_SLT 4'h5
`endif
`ifndef ALU_SLTU
`define ALU_SLTU 4'h6
`endif
`ifndef ALU_SHL
`define ALU_SHL 4'h7
`endif
`ifndef ALU_SHR
`define ALU_SHR 4'h8
`endif
`ifndef ALU_SRA
`define ALU_SRA 4'h9
`endif

module tb_alu_arbiter;
    localparam int DW = `DWORD_BITS;
    localparam int OW = `ALU_TYPE_BITS;
`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    alu_arbiter_if #(.DATA_SIZE(DW), .OP_BITS(OW)) ifc ();
    alu_arbiter #(.DATA_SIZE(DW), .OP_BITS(OW)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_fn(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (op)
            `ALU_ADD:  return a + b;
            `ALU_SUB:  return a - b;
            `ALU_AND:  return a & b;
            `ALU_OR:   return a | b;
            `ALU_XOR:  return a ^ b;
            `ALU_SLT:  return ($signed(a) < $signed(b)) ? DW'(1) : '0;
            `ALU_SLTU: return (a < b) ? DW'(1) : '0;
            `ALU_SHL:  return a << b[4:0];
            `ALU_SHR:  return a >> b[4:0];
            `ALU_SRA:  return $signed(a) >>> b[4:0];
            default:   return '0;
        endcase
    endfunction

    // Behavioural stand-in for the shared ALU instance.
    assign ifc.alu_result = alu_fn(ifc.alu_op, ifc.alu_src1, ifc.alu_src2);
    assign ifc.alu_zero   = (ifc.alu_result == '0);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] vld,
                         input logic [OW-1:0] o0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                         input logic [OW-1:0] o1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                         input logic [1:0] rrdy, input logic fl);
        ifc.req_valid = vld;
        ifc.req_op0 = o0; ifc.req_a0 = a0; ifc.req_b0 = b0;
        ifc.req_op1 = o1; ifc.req_a1 = a1; ifc.req_b1 = b1;
        ifc.rsp_ready = rrdy;
        ifc.flush = fl;
    endtask

    // Inputs are driven 1 time unit after the rising edge; outputs are compared on the falling edge.
    task automatic expect_cycle(input string tag, input logic [1:0] rdy, input logic [1:0] vld,
                                input logic [DW-1:0] data, input logic zero);
        @(negedge clk);
        check({tag, ".req_ready"}, ifc.req_ready, rdy);
        check({tag, ".rsp_valid"}, ifc.rsp_valid, vld);
        check({tag, ".rsp_data"},  ifc.rsp_data,  data);
        check({tag, ".rsp_zero"},  ifc.rsp_zero,  zero);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]    vld;
        logic [OW-1:0] op0;
        logic [DW-1:0] a0, b0;
        logic [OW-1:0] op1;
        logic [DW-1:0] a1, b1;
        logic [1:0]    rrdy;
        logic          fl;
        logic [1:0]    x_rdy;
        logic [1:0]    x_vld;
        logic [DW-1:0] x_data;
        logic          x_zero;
    } vec_t;

    // Reference model: at most one outstanding transaction, kept as a queue entry.
    typedef struct {
        logic          owner;
        logic [OW-1:0] op;
        logic [DW-1:0] a, b;
    } issue_t;

    issue_t pend[$];
    bit     m_prio;

    task automatic model_cycle(input string tag);
        bit            busy, fire, both, can, win;
        logic [1:0]    x_vld, x_rdy;
        logic [OW-1:0] x_op;
        logic [DW-1:0] x_s1, x_s2;
        issue_t        e;
        @(negedge clk);
        busy  = (pend.size() != 0);
        x_op  = busy ? pend[0].op : OW'(`ALU_ADD);
        x_s1  = busy ? pend[0].a : '0;
        x_s2  = busy ? pend[0].b : '0;
        x_vld = busy ? (pend[0].owner ? 2'b10 : 2'b01) : 2'b00;
        fire  = busy && ifc.rsp_ready[pend[0].owner];
        both  = (ifc.req_valid == 2'b11);
        win   = both ? (RR ? m_prio : 1'b0) : ifc.req_valid[1];
        can   = (ifc.req_valid != 2'b00) && !ifc.flush && (!busy || fire);
        x_rdy = can ? (win ? 2'b10 : 2'b01) : 2'b00;
        check({tag, ".req_ready"}, ifc.req_ready, x_rdy);
        check({tag, ".rsp_valid"}, ifc.rsp_valid, x_vld);
        check({tag, ".alu_op"},    ifc.alu_op,    x_op);
        check({tag, ".alu_src1"},  ifc.alu_src1,  x_s1);
        check({tag, ".alu_src2"},  ifc.alu_src2,  x_s2);
        check({tag, ".rsp_data"},  ifc.rsp_data,  alu_fn(x_op, x_s1, x_s2));
        check({tag, ".rsp_zero"},  ifc.rsp_zero,  alu_fn(x_op, x_s1, x_s2) == '0);
        if (ifc.flush) begin
            pend.delete();
        end else begin
            if (fire) void'(pend.pop_front());
            if (can) begin
                e.owner = win;
                e.op    = win ? ifc.req_op1 : ifc.req_op0;
                e.a     = win ? ifc.req_a1  : ifc.req_a0;
                e.b     = win ? ifc.req_b1  : ifc.req_b0;
                pend.push_back(e);
                if (both) m_prio = !win;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t          tbl[8];
        logic [OW-1:0] ops[10];
        logic [1:0]    x_rdy, x_vld;
        logic [DW-1:0] ra, rb;
        bit            own;

        tbl[0] = '{2'b01, `ALU_ADD, 32'd5, 32'd7, `ALU_ADD, 32'd0, 32'd0, 2'b01, 1'b0,
                   2'b01, 2'b00, 32'd0, 1'b1};
        tbl[1] = '{2'b00, `ALU_ADD, 32'd5, 32'd7, `ALU_ADD, 32'd0, 32'd0, 2'b01, 1'b0,
                   2'b00, 2'b01, 32'd12, 1'b0};
        tbl[2] = '{2'b10, `ALU_ADD, 32'd0, 32'd0, `ALU_SLT, 32'hFFFF_FFFF, 32'd0, 2'b00, 1'b0,
                   2'b10, 2'b00, 32'd0, 1'b1};
        for (int i = 3; i < 6; i++)
            tbl[i] = '{2'b10, `ALU_ADD, 32'd0, 32'd0, `ALU_SLT, 32'hFFFF_FFFF, 32'd0, 2'b00, 1'b0,
                       2'b00, 2'b10, 32'd1, 1'b0};
        tbl[6] = '{2'b00, `ALU_ADD, 32'd0, 32'd0, `ALU_SLT, 32'hFFFF_FFFF, 32'd0, 2'b10, 1'b0,
                   2'b00, 2'b10, 32'd1, 1'b0};
        tbl[7] = '{2'b00, `ALU_ADD, 32'd0, 32'd0, `ALU_ADD, 32'd0, 32'd0, 2'b11, 1'b0,
                   2'b00, 2'b00, 32'd0, 1'b1};

        drive(2'b00, `ALU_ADD, '0, '0, `ALU_ADD, '0, '0, 2'b00, 1'b0);
        #12;
        check("reset.req_ready", ifc.req_ready, 2'b00);
        check("reset.rsp_valid", ifc.rsp_valid, 2'b00);
        check("reset.alu_op",    ifc.alu_op,    OW'(`ALU_ADD));
        check("reset.rsp_data",  ifc.rsp_data,  DW'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table: single ADD, then SLT with three cycles of backpressure.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].vld, tbl[i].op0, tbl[i].a0, tbl[i].b0, tbl[i].op1, tbl[i].a1, tbl[i].b1,
                  tbl[i].rrdy, tbl[i].fl);
            expect_cycle($sformatf("tbl%0d", i), tbl[i].x_rdy, tbl[i].x_vld, tbl[i].x_data,
                         tbl[i].x_zero);
        end

        // Continuous contention.
        drive(2'b11, `ALU_SUB, 32'd3, 32'd3, `ALU_XOR, 32'hF, 32'h1, 2'b11, 1'b0);
        for (int k = 0; k < 6; k++) begin
            x_rdy = (RR && (k % 2 == 1)) ? 2'b10 : 2'b01;
            own   = RR && (k % 2 == 0) && (k != 0);
            x_vld = (k == 0) ? 2'b00 : (own ? 2'b10 : 2'b01);
            expect_cycle($sformatf("contend%0d", k), x_rdy, x_vld, own ? 32'hE : 32'd0,
                         (k == 0) ? 1'b1 : !own);
        end
        own = RR;
        drive(2'b00, `ALU_SUB, 32'd3, 32'd3, `ALU_XOR, 32'hF, 32'h1, 2'b11, 1'b0);
        expect_cycle("contend_drain", 2'b00, own ? 2'b10 : 2'b01, own ? 32'hE : 32'd0, !own);
        expect_cycle("contend_idle", 2'b00, 2'b00, 32'd0, 1'b1);

        // Back-to-back issue with no idle gap.
        drive(2'b01, `ALU_ADD, 32'd2, 32'd3, `ALU_ADD, 32'd0, 32'd0, 2'b01, 1'b0);
        expect_cycle("b2b0", 2'b01, 2'b00, 32'd0, 1'b1);
        drive(2'b01, `ALU_SHL, 32'd1, 32'd4, `ALU_ADD, 32'd0, 32'd0, 2'b01, 1'b0);
        expect_cycle("b2b1", 2'b01, 2'b01, 32'd5, 1'b0);
        drive(2'b00, `ALU_SHL, 32'd1, 32'd4, `ALU_ADD, 32'd0, 32'd0, 2'b01, 1'b0);
        expect_cycle("b2b2", 2'b00, 2'b01, 32'd16, 1'b0);
        expect_cycle("b2b3", 2'b00, 2'b00, 32'd0, 1'b1);

        // Flush while busy with requester 1 waiting.
        drive(2'b10, `ALU_ADD, 32'd0, 32'd0, `ALU_AND, 32'hFF, 32'h0F, 2'b00, 1'b0);
        expect_cycle("flush0", 2'b10, 2'b00, 32'd0, 1'b1);
        ifc.flush = 1'b1;
        expect_cycle("flush1", 2'b00, 2'b10, 32'h0F, 1'b0);
        ifc.flush = 1'b0;
        expect_cycle("flush2", 2'b10, 2'b00, 32'd0, 1'b1);
        drive(2'b00, `ALU_ADD, 32'd0, 32'd0, `ALU_AND, 32'hFF, 32'h0F, 2'b10, 1'b0);
        expect_cycle("flush3", 2'b00, 2'b10, 32'h0F, 1'b0);
        expect_cycle("flush4", 2'b00, 2'b00, 32'd0, 1'b1);

        // Asynchronous reset while busy; contention beforehand moves the pointer.
        drive(2'b11, `ALU_ADD, 32'd1, 32'd1, `ALU_ADD, 32'd2, 32'd2, 2'b00, 1'b0);
        expect_cycle("areset0", 2'b01, 2'b00, 32'd0, 1'b1);
        ifc.req_valid = 2'b00;
        @(negedge clk);
        check("areset.busy_valid", ifc.rsp_valid, 2'b01);
        check("areset.busy_data",  ifc.rsp_data,  DW'(2));
        #2 rst_n = 1'b0;
        #1;
        check("areset.rsp_valid", ifc.rsp_valid, 2'b00);
        check("areset.alu_src1",  ifc.alu_src1,  DW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ifc.req_valid = 2'b11;
        expect_cycle("areset.prio", 2'b01, 2'b00, 32'd0, 1'b1);

        // Random traffic against the reference model, starting from a fresh reset.
        drive(2'b00, `ALU_ADD, '0, '0, `ALU_ADD, '0, '0, 2'b00, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        pend.delete();
        m_prio = 1'b0;
        ops = '{`ALU_ADD, `ALU_SUB, `ALU_AND, `ALU_OR, `ALU_XOR,
                `ALU_SLT, `ALU_SLTU, `ALU_SHL, `ALU_SHR, `ALU_SRA};
        for (int c = 0; c < 400; c++) begin
            ra = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom());
            rb = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom());
            drive(2'($urandom_range(0, 3)),
                  ops[$urandom_range(0, 9)], ra, rb,
                  ops[$urandom_range(0, 9)], rb, ra,
                  2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
            model_cycle($sformatf("rand%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
